// File: rtl/nfc_pkg.sv
// Shared types for the NAND command-port arbiter: FSM states, command code, status flags.
// Pure declarations; no timing or flow control of its own.
package nfc_pkg;

   localparam int ROW_ADDR_WIDTH = 24;

   typedef enum logic [1:0] {IDLE, START, WAIT, RESP} nfc_arb_state_t;

   typedef logic [2:0] nfc_cmd_t;

   typedef struct packed {
      logic p;
      logic e;
      logic r;
   } nfc_err_t;

   // Port index reached by stepping ofs places up from base, wrapping at n.
   function automatic int rr_index(input int base, input int ofs, input int n);
      return (base + ofs) % n;
   endfunction

endpackage

// File: rtl/nfc_rr_pick.sv
// Round-robin winner select: first set request at or above ptr, wrapping; combinational, 0 cycles.
// No flow control; the parent only consults it while idle.
module nfc_rr_pick
   import nfc_pkg::*;
#(
   parameter int NREQ = 2
) (
   input  logic [NREQ-1:0]         req,
   input  logic [$clog2(NREQ)-1:0] ptr,
   output logic [NREQ-1:0]         win,
   output logic [$clog2(NREQ)-1:0] idx
);

   localparam int PW = $clog2(NREQ);

   logic found;

   always_comb begin
      win   = '0;
      idx   = '0;
      found = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (!found && req[rr_index(int'(ptr), i, NREQ)]) begin
            found = 1'b1;
            win[rr_index(int'(ptr), i, NREQ)] = 1'b1;
            idx = PW'(rr_index(int'(ptr), i, NREQ));
         end
      end
   end

endmodule

// File: rtl/nfc_cmd_arbiter.sv
// Round-robin sharing of the NAND controller command port; req->nfc_strt 1 cycle, done_o 1 cycle after nfc_done.
// No backpressure: requesters hold req_i until done_o; one command in flight, watchdog forces completion.
module nfc_cmd_arbiter
   import nfc_pkg::*;
#(
   parameter int NREQ    = 2,
   parameter int ROW_AW  = ROW_ADDR_WIDTH,
   parameter int TIMEOUT = 65535
) (
   input  logic                     CLK,
   input  logic                     RES,
   input  logic [NREQ-1:0]          req_i,
   input  logic [NREQ*3-1:0]        cmd_i,
   input  logic [NREQ*ROW_AW-1:0]   addr_i,
   output logic [NREQ-1:0]          gnt_o,
   output logic [NREQ-1:0]          done_o,
   output logic [2:0]               err_o,
   output logic                     timeout_o,
   output nfc_cmd_t                 nfc_cmd,
   output logic [ROW_AW-1:0]        RWA,
   output logic                     nfc_strt,
   input  logic                     nfc_done,
   input  logic                     PErr,
   input  logic                     EErr,
   input  logic                     RErr,
   output logic                     busy_o
);

   localparam int PW = $clog2(NREQ);
   localparam int WW = $clog2(TIMEOUT + 1);
   localparam logic [WW-1:0] WD_TERM = WW'(TIMEOUT - 1);
   localparam logic [PW-1:0] LAST_PORT = PW'(NREQ - 1);

   nfc_arb_state_t  state;
   logic [PW-1:0]   rr_ptr;
   logic [PW-1:0]   w_idx;
   logic [PW-1:0]   pick_idx;
   logic [NREQ-1:0] pick_win;
   logic [WW-1:0]   wd_cnt;
   nfc_err_t        stat;

   assign stat = '{p: PErr, e: EErr, r: RErr};

   nfc_rr_pick #(.NREQ(NREQ)) u_pick (
      .req (req_i),
      .ptr (rr_ptr),
      .win (pick_win),
      .idx (pick_idx)
   );

   always_ff @(posedge CLK) begin
      if (!RES) begin
         state     <= IDLE;
         rr_ptr    <= '0;
         w_idx     <= '0;
         wd_cnt    <= '0;
         gnt_o     <= '0;
         done_o    <= '0;
         err_o     <= '0;
         timeout_o <= 1'b0;
         nfc_cmd   <= '0;
         RWA       <= '0;
         nfc_strt  <= 1'b0;
         busy_o    <= 1'b0;
      end else begin
         done_o    <= '0;
         timeout_o <= 1'b0;
         nfc_strt  <= 1'b0;
         case (state)
            IDLE: begin
               if (|req_i) begin
                  state    <= START;
                  gnt_o    <= pick_win;
                  w_idx    <= pick_idx;
                  nfc_strt <= 1'b1;
                  nfc_cmd  <= cmd_i[int'(pick_idx)*3 +: 3];
                  RWA      <= addr_i[int'(pick_idx)*ROW_AW +: ROW_AW];
                  busy_o   <= 1'b1;
               end
            end
            START: begin
               state  <= WAIT;
               wd_cnt <= '0;
            end
            WAIT: begin
               if (wd_cnt != '1)
                  wd_cnt <= wd_cnt + 1'b1;
               // A real completion on the terminal-count cycle beats the watchdog.
               if (nfc_done) begin
                  err_o  <= stat;
                  done_o <= gnt_o;
                  state  <= RESP;
               end else if (wd_cnt == WD_TERM) begin
                  err_o     <= '0;
                  done_o    <= gnt_o;
                  timeout_o <= 1'b1;
                  state     <= RESP;
               end
            end
            RESP: begin
               state  <= IDLE;
               gnt_o  <= '0;
               busy_o <= 1'b0;
               rr_ptr <= (w_idx == LAST_PORT) ? '0 : w_idx + 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_nfc_cmd_arbiter.sv
// Bench for nfc_cmd_arbiter: directed scenarios plus randomized commands against a transaction-level model.
// The model predicts winner and completion cycle from round-robin order and watchdog length.
module tb_nfc_cmd_arbiter;

   localparam int NREQ = 2;
   localparam int AW   = 16;
   localparam int TO   = 16;

   logic              CLK = 1'b0;
   logic              RES;
   logic [NREQ-1:0]   req_i;
   logic [NREQ*3-1:0] cmd_i;
   logic [NREQ*AW-1:0] addr_i;
   logic [NREQ-1:0]   gnt_o, done_o;
   logic [2:0]        err_o;
   logic              timeout_o;
   logic [2:0]        nfc_cmd;
   logic [AW-1:0]     RWA;
   logic              nfc_strt;
   logic              nfc_done, PErr, EErr, RErr;
   logic              busy_o;

   int tests = 0;
   int fails = 0;
   int ptr_m = 0;
   logic [2:0] err_hold = 3'b000;

   nfc_cmd_arbiter #(.NREQ(NREQ), .ROW_AW(AW), .TIMEOUT(TO)) dut (
      .CLK(CLK), .RES(RES), .req_i(req_i), .cmd_i(cmd_i), .addr_i(addr_i),
      .gnt_o(gnt_o), .done_o(done_o), .err_o(err_o), .timeout_o(timeout_o),
      .nfc_cmd(nfc_cmd), .RWA(RWA), .nfc_strt(nfc_strt), .nfc_done(nfc_done),
      .PErr(PErr), .EErr(EErr), .RErr(RErr), .busy_o(busy_o)
   );

   always #5 CLK = ~CLK;

   task automatic tick;
      @(posedge CLK);
      #1;
   endtask

   // One full command. d = WAIT cycles before nfc_done (d >= TO means never in time).
   task automatic run_cmd(input logic [NREQ-1:0] m, input int d, input logic [2:0] e,
                          input bit scramble, input string tag);
      int w;
      int lat;
      bit to;
      logic [2:0] c;
      logic [AW-1:0] a;
      logic [NREQ-1:0] oh;
      logic [NREQ-1:0] exp_done;
      logic [2:0] exp_err;
      w = -1;
      for (int i = 0; i < NREQ; i++)
         if (w < 0 && m[(ptr_m + i) % NREQ]) w = (ptr_m + i) % NREQ;
      oh = '0;
      oh[w] = 1'b1;
      c = 3'($urandom);
      a = AW'($urandom);
      req_i  = m;
      cmd_i  = (NREQ*3)'($urandom);
      addr_i = (NREQ*AW)'({$urandom, $urandom});
      cmd_i[w*3 +: 3]   = c;
      addr_i[w*AW +: AW] = a;
      tick;
      tests++;
      if ({gnt_o, done_o, timeout_o, nfc_strt, busy_o, nfc_cmd, RWA} !== {oh, {NREQ{1'b0}}, 1'b0, 1'b1, 1'b1, c, a}) begin
         fails++;
         $display("FAIL %s start: gnt=%b done=%b to=%b strt=%b busy=%b cmd=%b rwa=%h, want gnt=%b strt=1 busy=1 cmd=%b rwa=%h",
                  tag, gnt_o, done_o, timeout_o, nfc_strt, busy_o, nfc_cmd, RWA, oh, c, a);
      end
      if (scramble) begin
         req_i  = NREQ'($urandom);
         cmd_i  = (NREQ*3)'($urandom);
         addr_i = (NREQ*AW)'({$urandom, $urandom});
      end
      nfc_done = 1'b1;
      {PErr, EErr, RErr} = 3'($urandom);
      lat = (d + 2 < TO + 1) ? d + 2 : TO + 1;
      to  = (d + 2 > TO + 1);
      exp_err = to ? 3'b000 : e;
      for (int cyc = 1; cyc <= lat; cyc++) begin
         tick;
         exp_done = (cyc == lat) ? oh : '0;
         tests++;
         if ({gnt_o, done_o, timeout_o, nfc_strt, busy_o, nfc_cmd, RWA} !==
             {oh, exp_done, (cyc == lat) && to, 1'b0, 1'b1, c, a}) begin
            fails++;
            $display("FAIL %s cyc%0d: gnt=%b done=%b to=%b strt=%b busy=%b cmd=%b rwa=%h, want gnt=%b done=%b to=%b cmd=%b rwa=%h",
                     tag, cyc, gnt_o, done_o, timeout_o, nfc_strt, busy_o, nfc_cmd, RWA,
                     oh, exp_done, (cyc == lat) && to, c, a);
         end
         if (cyc == lat) begin
            tests++;
            if (err_o !== exp_err) begin
               fails++;
               $display("FAIL %s err: got %b want %b", tag, err_o, exp_err);
            end
         end
         if (cyc == d + 1) begin
            nfc_done = 1'b1;
            {PErr, EErr, RErr} = e;
         end else begin
            nfc_done = 1'b0;
            {PErr, EErr, RErr} = 3'($urandom);
         end
      end
      tick;
      tests++;
      if ({gnt_o, done_o, timeout_o, nfc_strt, busy_o, err_o} !== {{NREQ{1'b0}}, {NREQ{1'b0}}, 1'b0, 1'b0, 1'b0, exp_err}) begin
         fails++;
         $display("FAIL %s idle: gnt=%b done=%b to=%b strt=%b busy=%b err=%b, want all 0 err=%b",
                  tag, gnt_o, done_o, timeout_o, nfc_strt, busy_o, err_o, exp_err);
      end
      nfc_done = 1'b0;
      ptr_m = (w + 1) % NREQ;
      err_hold = exp_err;
   endtask

   task automatic check_all_zero(input string tag);
      tests++;
      if ({gnt_o, done_o, err_o, timeout_o, nfc_cmd, RWA, nfc_strt, busy_o} !== '0) begin
         fails++;
         $display("FAIL %s: gnt=%b done=%b err=%b to=%b cmd=%b rwa=%h strt=%b busy=%b, want all 0",
                  tag, gnt_o, done_o, err_o, timeout_o, nfc_cmd, RWA, nfc_strt, busy_o);
      end
   endtask

   task automatic test_reset;
      RES = 1'b0;
      req_i = '1;
      nfc_done = 1'b1;
      tick;
      tick;
      check_all_zero("reset");
      RES = 1'b1;
      req_i = '0;
      nfc_done = 1'b0;
      ptr_m = 0;
      err_hold = 3'b000;
      tick;
      check_all_zero("reset_idle");
   endtask

   task automatic test_back_to_back;
      for (int k = 0; k < 4; k++)
         run_cmd(2'b11, 3 + k, 3'($urandom), 1'b0, $sformatf("b2b%0d", k));
   endtask

   task automatic test_single;
      int w;
      req_i = '0;
      cmd_i = '0;
      addr_i = '0;
      cmd_i[2:0] = 3'b001;
      addr_i[AW-1:0] = 16'h0123;
      w = ptr_m;
      req_i = 2'b01;
      tick;
      tests++;
      if ({gnt_o, nfc_strt, nfc_cmd, RWA} !== {2'b01, 1'b1, 3'b001, 16'h0123}) begin
         fails++;
         $display("FAIL single_start: gnt=%b strt=%b cmd=%b rwa=%h, want 01 1 001 0123",
                  gnt_o, nfc_strt, nfc_cmd, RWA);
      end
      for (int cyc = 1; cyc <= 10; cyc++) begin
         nfc_done = (cyc == 10);
         {PErr, EErr, RErr} = 3'b000;
         tick;
         if (cyc < 10) begin
            tests++;
            if (done_o !== 2'b00) begin
               fails++;
               $display("FAIL single_early cyc%0d: done=%b want 00", cyc, done_o);
            end
         end
      end
      nfc_done = 1'b0;
      tests++;
      if ({done_o, err_o, timeout_o} !== {2'b01, 3'b000, 1'b0}) begin
         fails++;
         $display("FAIL single_done: done=%b err=%b to=%b, want 01 000 0", done_o, err_o, timeout_o);
      end
      req_i = '0;
      tick;
      ptr_m = (w + 1) % NREQ;
      err_hold = 3'b000;
   endtask

   task automatic test_error;
      run_cmd(2'b10, 5, 3'b100, 1'b0, "perr");
   endtask

   task automatic test_timeout;
      run_cmd(2'b01, 1000, 3'b111, 1'b1, "timeout");
   endtask

   task automatic test_done_at_terminal;
      run_cmd(2'b10, TO - 1, 3'b011, 1'b1, "terminal");
      run_cmd(2'b01, TO - 2, 3'b101, 1'b0, "pre_terminal");
   endtask

   task automatic test_reset_mid;
      run_cmd(2'b01, 2, 3'b010, 1'b0, "pre_abort");
      req_i = 2'b11;
      tick;
      tests++;
      if ({gnt_o, nfc_strt} !== {2'b10, 1'b1}) begin
         fails++;
         $display("FAIL abort_start: gnt=%b strt=%b want 10 1", gnt_o, nfc_strt);
      end
      for (int k = 0; k < 4; k++) tick;
      RES = 1'b0;
      tick;
      check_all_zero("abort_reset");
      RES = 1'b1;
      req_i = '0;
      for (int k = 0; k < 3; k++) begin
         nfc_done = 1'b1;
         {PErr, EErr, RErr} = 3'b111;
         tick;
         tests++;
         if ({done_o, busy_o, nfc_strt, gnt_o} !== '0) begin
            fails++;
            $display("FAIL abort_stray%0d: done=%b busy=%b strt=%b gnt=%b want 0", k, done_o, busy_o, nfc_strt, gnt_o);
         end
      end
      nfc_done = 1'b0;
      ptr_m = 0;
      err_hold = 3'b000;
      run_cmd(2'b11, 4, 3'b001, 1'b0, "post_abort_11");
      run_cmd(2'b10, 1, 3'b000, 1'b0, "post_abort_10");
   endtask

   task automatic test_random;
      logic [NREQ-1:0] m;
      for (int k = 0; k < 40; k++) begin
         m = NREQ'($urandom_range(1, (1 << NREQ) - 1));
         run_cmd(m, $urandom_range(0, TO + 4), 3'($urandom), 1'($urandom), $sformatf("rnd%0d", k));
         req_i = '0;
         if ($urandom_range(0, 1) == 1) tick;
      end
   endtask

   initial begin
      RES = 1'b0;
      req_i = '0;
      cmd_i = '0;
      addr_i = '0;
      nfc_done = 1'b0;
      PErr = 1'b0;
      EErr = 1'b0;
      RErr = 1'b0;
      test_reset;
      test_back_to_back;
      req_i = '0;
      tick;
      test_single;
      test_error;
      test_timeout;
      req_i = '0;
      test_done_at_terminal;
      req_i = '0;
      tick;
      test_reset_mid;
      req_i = '0;
      test_random;
      req_i = '0;
      tick;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
